// File: rtl/axi_wr_slave_frontend_pkg.sv
// bridge_utils: shared response, command and B-channel types for the AXI write front end
package bridge_utils;
  localparam int ID_W = 4;
  localparam int ADDR_W = 32;
  typedef enum logic [1:0] {OKAY = 2'd0, EXOKAY = 2'd1, SLVERR = 2'd2, DECERR = 2'd3} resp_t;
  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [ADDR_W-1:0] addr;
    logic [3:0]        len;
    logic [2:0]        size;
    logic [1:0]        burst;
  } aw_cmd_t;
  typedef struct packed {
    logic [ID_W-1:0] id;
    logic            err;
  } b_info_t;
  typedef enum logic {B_IDLE, B_SEND} b_state_t;
  function automatic resp_t merge_resp(input logic err, input logic [1:0] r);
    return err ? (r == DECERR ? DECERR : SLVERR) : resp_t'(r);
  endfunction
endpackage

// File: rtl/axi_wr_slave_frontend_sync_fifo.sv
// sync_fifo: single-clock FIFO with full/empty flags and synchronous active-low reset
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int PW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW:0] wr_ptr, rd_ptr;
  assign empty = wr_ptr == rd_ptr;
  assign full = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign dout = mem[rd_ptr[PW-1:0]];
  // pointer update; extra MSB distinguishes full from empty
  always_ff @(posedge clk)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  // storage write, no reset needed since pointers gate visibility
  always_ff @(posedge clk)
    if (push && !full) mem[wr_ptr[PW-1:0]] <= din;
endmodule

// File: rtl/axi_wr_slave_frontend.sv
// axi_wr_slave_frontend: AXI3 write-slave front end buffering AW/W for the engine, in-order B; AXI_WID_CHECK_EN adds WID check
module axi_wr_slave_frontend
  import bridge_utils::*;
#(
  parameter int ADDR_WIDTH      = ADDR_W,
  parameter int DATA_WIDTH      = 32,
  parameter int ID_WIDTH        = ID_W,
  parameter int MAX_OUTSTANDING = 4,
  parameter int W_DEPTH         = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [ID_WIDTH-1:0]     awid,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic [3:0]              awlen,
  input  logic [2:0]              awsize,
  input  logic [1:0]              awburst,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [ID_WIDTH-1:0]     wid,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wlast,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [ID_WIDTH-1:0]     bid,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready,
  output logic                    cmd_valid,
  input  logic                    cmd_ready,
  output logic [ID_WIDTH-1:0]     cmd_id,
  output logic [ADDR_WIDTH-1:0]   cmd_addr,
  output logic [3:0]              cmd_len,
  output logic [2:0]              cmd_size,
  output logic [1:0]              cmd_burst,
  output logic                    wd_valid,
  input  logic                    wd_ready,
  output logic [DATA_WIDTH-1:0]   wd_data,
  output logic [DATA_WIDTH/8-1:0] wd_strb,
  output logic                    wd_last,
  input  logic                    rsp_valid,
  output logic                    rsp_ready,
  input  logic [1:0]              rsp_resp
);
  localparam int OW = $clog2(MAX_OUTSTANDING) + 1;
  localparam int WW = DATA_WIDTH + DATA_WIDTH / 8 + 1;
  aw_cmd_t aw_in, cmd_head;
  b_info_t bi_in, bi_head;
  b_state_t state, state_nx;
  resp_t bresp_q;
  logic [OW-1:0] outstanding;
  logic [ID_WIDTH-1:0] pend_id;
  logic [3:0] pend_len, beat_cnt;
  logic err, beat_err, last_beat, aw_hs, w_hs, b_hs, rsp_hs;
  logic cmd_empty, pend_empty, wf_full, wf_empty, bi_empty;
  logic cmd_full_unused, pend_full_unused, bi_full_unused;
  assign awready = rst_n && (outstanding < OW'(MAX_OUTSTANDING));
  assign aw_hs = awvalid && awready;
  assign aw_in = '{id: awid, addr: awaddr, len: awlen, size: awsize, burst: awburst};
  assign cmd_valid = !cmd_empty;
  assign cmd_id = cmd_head.id;
  assign cmd_addr = cmd_head.addr;
  assign cmd_len = cmd_head.len;
  assign cmd_size = cmd_head.size;
  assign cmd_burst = cmd_head.burst;
  assign wready = rst_n && !pend_empty && !wf_full;
  assign w_hs = wvalid && wready;
  assign last_beat = beat_cnt == pend_len;
`ifdef AXI_WID_CHECK_EN
  assign beat_err = (wlast != last_beat) || (wid != pend_id);
`else
  logic wid_unused;
  assign wid_unused = ^wid;
  assign beat_err = wlast != last_beat;
`endif
  assign wd_valid = !wf_empty;
  assign bi_in = '{id: pend_id, err: err || beat_err};
  assign rsp_hs = rsp_valid && rsp_ready;
  assign b_hs = bvalid && bready;
  assign bresp = bresp_q;

  sync_fifo #(.WIDTH($bits(aw_cmd_t)), .DEPTH(MAX_OUTSTANDING)) u_cmd (
    .clk(clk), .rst_n(rst_n), .push(aw_hs), .din(aw_in), .pop(cmd_valid && cmd_ready),
    .dout(cmd_head), .full(cmd_full_unused), .empty(cmd_empty));
  sync_fifo #(.WIDTH(ID_WIDTH + 4), .DEPTH(MAX_OUTSTANDING)) u_pend (
    .clk(clk), .rst_n(rst_n), .push(aw_hs), .din({awid, awlen}), .pop(w_hs && last_beat),
    .dout({pend_id, pend_len}), .full(pend_full_unused), .empty(pend_empty));
  sync_fifo #(.WIDTH(WW), .DEPTH(W_DEPTH)) u_wdat (
    .clk(clk), .rst_n(rst_n), .push(w_hs), .din({wdata, wstrb, last_beat}), .pop(wd_valid && wd_ready),
    .dout({wd_data, wd_strb, wd_last}), .full(wf_full), .empty(wf_empty));
  sync_fifo #(.WIDTH($bits(b_info_t)), .DEPTH(MAX_OUTSTANDING)) u_binfo (
    .clk(clk), .rst_n(rst_n), .push(w_hs && last_beat), .din(bi_in), .pop(b_hs),
    .dout(bi_head), .full(bi_full_unused), .empty(bi_empty));

  // beat position and sticky error of the head pending burst; length is set by awlen, not wlast
  always_ff @(posedge clk)
    if (!rst_n || (w_hs && last_beat)) begin
      beat_cnt <= '0;
      err <= 1'b0;
    end else if (w_hs) begin
      beat_cnt <= beat_cnt + 1'b1;
      err <= err || beat_err;
    end
  // bursts accepted on AW but not yet completed on B
  always_ff @(posedge clk)
    outstanding <= !rst_n ? '0 : outstanding + OW'(aw_hs) - OW'(b_hs);
  // B state register
  always_ff @(posedge clk)
    state <= !rst_n ? B_IDLE : state_nx;
  // B next state: take one engine response, then hold it until the master accepts
  always_comb
    state_nx = state == B_IDLE ? (rsp_hs ? B_SEND : B_IDLE) : (bready ? B_IDLE : B_SEND);
  // B outputs; rsp_ready only when a completed burst is waiting for its response
  always_comb begin
    rsp_ready = state == B_IDLE && !bi_empty;
    bvalid = state == B_SEND;
    bid = bvalid ? bi_head.id : '0;
  end
  // merged response, latched at the engine handshake and held through B_SEND
  always_ff @(posedge clk)
    if (!rst_n) bresp_q <= OKAY;
    else if (rsp_hs) bresp_q <= merge_resp(bi_head.err, rsp_resp);
endmodule
